// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter/sequencer in front of the 512x16 S-Machine data memory.
// Latency: req sampled at edge k -> registered ack in the cycle after edge k+MEM_LAT; one access per MEM_LAT+2 cycles.
// Backpressure: requesters hold req/we/addr/wdata until ack; a losing requester waits, never dropped.
// Option: define DATA_MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties, port 1 may starve).
module data_mem_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 9,
  parameter int MEM_LAT  = 1,
  parameter int RO_ADDR0 = 4,
  parameter int RO_ADDR1 = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              wr_err,
  output logic              busy,
  output logic              mem_read_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Counter is 4 bits wide, enough for MEM_LAT up to 15.
  localparam logic [3:0]        LAT_LOAD = 4'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] RO0      = ADDR_W'(RO_ADDR0);
  localparam logic [ADDR_W-1:0] RO1      = ADDR_W'(RO_ADDR1);

  state_t              state_q;
  state_t              state_d;
  logic                grant;
  logic                win_d;
  logic                win_q;
  logic                lat_we;
  logic                lat_ro;
  logic [3:0]          lat_cnt;
  logic                acc_done;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_ro;

`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
  logic                last_gnt;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> ACCESS on any request, ACCESS holds MEM_LAT cycles, RESP lasts one cycle.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (lat_cnt == 4'd0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Winner selection: a lone requester always wins; ties resolved by priority scheme.
  always_comb begin
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    win_d = ~req0;
`else
    win_d = (req0 && req1) ? ~last_gnt : ~req0;
`endif
  end

  // Request fields of the winner, and whether it targets a switch-input word.
  always_comb begin
    sel_we    = win_d ? we1    : we0;
    sel_addr  = win_d ? addr1  : addr0;
    sel_wdata = win_d ? wdata1 : wdata0;
    sel_ro    = (sel_addr == RO0) || (sel_addr == RO1);
  end

  assign acc_done = (state_q == ST_ACCESS) && (lat_cnt == 4'd0);

  // Strobe only during ACCESS so the memory never sees a spurious write; dropped writes never strobe.
  assign mem_read_write = (state_q == ST_ACCESS) && lat_we && !lat_ro;
  assign busy           = (state_q != ST_IDLE);

  // Latch the granted request; mem_addr/mem_data_in hold their last values outside ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q       <= 1'b0;
      lat_we      <= 1'b0;
      lat_ro      <= 1'b0;
      lat_cnt     <= 4'd0;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else if (grant) begin
      win_q       <= win_d;
      lat_we      <= sel_we;
      lat_ro      <= sel_ro;
      lat_cnt     <= LAT_LOAD;
      mem_addr    <= sel_addr;
      mem_data_in <= sel_wdata;
    end else if ((state_q == ST_ACCESS) && (lat_cnt != 4'd0)) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Registered response: one-cycle ack/wr_err pulse, rdata captured at the end of ACCESS and held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      wr_err <= 1'b0;
      rdata  <= '0;
    end else begin
      ack0   <= acc_done && !win_q;
      ack1   <= acc_done && win_q;
      wr_err <= acc_done && lat_we && lat_ro;
      if (acc_done) begin
        rdata <= mem_data_out;
      end
    end
  end

`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
  // Remember the last served port; starts at 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (state_q == ST_RESP) begin
      last_gnt <= win_q;
    end
  end
`endif

endmodule
